// File: rtl/adpcm_decoder.sv
// adpcm_decoder -- IMA ADPCM decoder (4-bit code -> signed 16-bit PCM)
//
// The decode half of the CIC + ADPCM path. It takes the compressor's codes and
// rebuilds PCM. There is one FSM pass per code (IDLE -> CALC -> UPDATE), so it
// accepts one code every 3 clocks.
//
// Optional build macro:
//   ADPCM_DEC_DC_BLOCK_EN - adds a first-order DC-blocking high-pass on pcm_out:
//     y = x - x_prev + y_prev - (y_prev>>>8).
//     The output is saturated to 16 bits and the latency does not change.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   clear      synchronous stream restart (predictor/index to 0, FSM to IDLE)
//   in_valid   code strobe
//   in_code    4-bit code: bit3 = sign, bits2:0 = magnitude
//   in_ready   decoder can take a code this cycle (FSM in IDLE)
//   pcm_valid  one-cycle pulse when pcm_out is updated
//   pcm_out    reconstructed sample, held between pulses
//   step_idx   current step-table index, 0..IDX_MAX
//   overrun    sticky; a code arrived while in_ready was low (cleared only by rst)
module adpcm_decoder #(
  parameter int PCM_W   = 16,
  parameter int IDX_MAX = 88
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [3:0]              in_code,
  output logic                    in_ready,
  output logic                    pcm_valid,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic [6:0]              step_idx,
  output logic                    overrun
);

  localparam logic signed [8:0] IDX_MAX_S = 9'(IDX_MAX);
  localparam logic [6:0]        IDX_MAX_U = 7'(IDX_MAX);
  localparam logic signed [19:0] SAT_HI  = 20'sd32767;
  localparam logic signed [19:0] SAT_LO  = -20'sd32768;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;

  state_t              state_q, state_d;
  logic signed [15:0]  pred_q;
  logic [6:0]          idx_q;

  logic [3:0]          code_p0;
  logic [15:0]         step_p0;
  logic [16:0]         diff_p1;

  logic                accept;
  logic signed [17:0]  pred_sum;
  logic signed [15:0]  pred_sat;
  logic [6:0]          idx_next;
  logic signed [15:0]  out_val;

  // IMA 16-bit step table as a combinational ROM
  function automatic logic [15:0] step_lookup(input logic [6:0] idx);
    logic [15:0] s;
    case (idx)
      7'd0:  s = 16'd7;     7'd1:  s = 16'd8;     7'd2:  s = 16'd9;     7'd3:  s = 16'd10;
      7'd4:  s = 16'd11;    7'd5:  s = 16'd12;    7'd6:  s = 16'd13;    7'd7:  s = 16'd14;
      7'd8:  s = 16'd16;    7'd9:  s = 16'd17;    7'd10: s = 16'd19;    7'd11: s = 16'd21;
      7'd12: s = 16'd23;    7'd13: s = 16'd25;    7'd14: s = 16'd28;    7'd15: s = 16'd31;
      7'd16: s = 16'd34;    7'd17: s = 16'd37;    7'd18: s = 16'd41;    7'd19: s = 16'd45;
      7'd20: s = 16'd50;    7'd21: s = 16'd55;    7'd22: s = 16'd60;    7'd23: s = 16'd66;
      7'd24: s = 16'd73;    7'd25: s = 16'd80;    7'd26: s = 16'd88;    7'd27: s = 16'd97;
      7'd28: s = 16'd107;   7'd29: s = 16'd118;   7'd30: s = 16'd130;   7'd31: s = 16'd143;
      7'd32: s = 16'd157;   7'd33: s = 16'd173;   7'd34: s = 16'd190;   7'd35: s = 16'd209;
      7'd36: s = 16'd230;   7'd37: s = 16'd253;   7'd38: s = 16'd279;   7'd39: s = 16'd307;
      7'd40: s = 16'd337;   7'd41: s = 16'd371;   7'd42: s = 16'd408;   7'd43: s = 16'd449;
      7'd44: s = 16'd494;   7'd45: s = 16'd544;   7'd46: s = 16'd598;   7'd47: s = 16'd658;
      7'd48: s = 16'd724;   7'd49: s = 16'd796;   7'd50: s = 16'd876;   7'd51: s = 16'd963;
      7'd52: s = 16'd1060;  7'd53: s = 16'd1166;  7'd54: s = 16'd1282;  7'd55: s = 16'd1411;
      7'd56: s = 16'd1552;  7'd57: s = 16'd1707;  7'd58: s = 16'd1878;  7'd59: s = 16'd2066;
      7'd60: s = 16'd2272;  7'd61: s = 16'd2499;  7'd62: s = 16'd2749;  7'd63: s = 16'd3024;
      7'd64: s = 16'd3327;  7'd65: s = 16'd3660;  7'd66: s = 16'd4026;  7'd67: s = 16'd4428;
      7'd68: s = 16'd4871;  7'd69: s = 16'd5358;  7'd70: s = 16'd5894;  7'd71: s = 16'd6484;
      7'd72: s = 16'd7132;  7'd73: s = 16'd7845;  7'd74: s = 16'd8630;  7'd75: s = 16'd9493;
      7'd76: s = 16'd10442; 7'd77: s = 16'd11487; 7'd78: s = 16'd12635; 7'd79: s = 16'd13899;
      7'd80: s = 16'd15289; 7'd81: s = 16'd16818; 7'd82: s = 16'd18500; 7'd83: s = 16'd20350;
      7'd84: s = 16'd22385; 7'd85: s = 16'd24623; 7'd86: s = 16'd27086; 7'd87: s = 16'd29794;
      default: s = 16'd32767;
    endcase
    return s;
  endfunction

  // Unsigned reconstruction delta. The worst case is 1.875*32767, which fits in 17 bits.
  function automatic logic [16:0] calc_diff(input logic [15:0] step, input logic [2:0] mag);
    logic [16:0] d;
    d = {4'b0, step[15:3]};
    if (mag[2]) d = d + {1'b0, step};
    if (mag[1]) d = d + {2'b0, step[15:1]};
    if (mag[0]) d = d + {3'b0, step[15:2]};
    return d;
  endfunction

  function automatic logic signed [15:0] sat_pcm(input logic signed [19:0] v);
    logic signed [15:0] r;
    if (v > SAT_HI)      r = 16'sh7FFF;
    else if (v < SAT_LO) r = 16'sh8000;
    else                 r = v[15:0];
    return r;
  endfunction

  // Index adjust {-1,-1,-1,-1,2,4,6,8}, clamped to [0, IDX_MAX]
  function automatic logic [6:0] clamp_idx(input logic [6:0] idx, input logic [2:0] mag);
    logic signed [8:0] adj;
    logic signed [8:0] t;
    logic [6:0]        r;
    adj = mag[2] ? $signed({5'b0, mag[1:0], 1'b0}) + 9'sd2 : -9'sd1;
    t   = $signed({2'b0, idx}) + adj;
    if (t < 9'sd0)          r = 7'd0;
    else if (t > IDX_MAX_S) r = IDX_MAX_U;
    else                    r = t[6:0];
    return r;
  endfunction

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid && !clear;
  assign step_idx = idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    pred_sum = code_p0[3] ? ({{2{pred_q[15]}}, pred_q} - $signed({1'b0, diff_p1}))
                          : ({{2{pred_q[15]}}, pred_q} + $signed({1'b0, diff_p1}));
    pred_sat = sat_pcm({{2{pred_sum[17]}}, pred_sum});
    idx_next = clamp_idx(idx_q, code_p0[2:0]);
  end

`ifdef ADPCM_DEC_DC_BLOCK_EN
  logic signed [19:0] x_prev_q, y_prev_q;
  logic signed [19:0] x_ext, y_raw;

  always_comb begin
    x_ext   = {{4{pred_sat[15]}}, pred_sat};
    y_raw   = x_ext - x_prev_q + y_prev_q - (y_prev_q >>> 8);
    out_val = sat_pcm(y_raw);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else if (state_q == UPDATE) begin
      x_prev_q <= x_ext;
      y_prev_q <= {{4{out_val[15]}}, out_val};
    end
  end
`else
  assign out_val = pred_sat;
`endif

  // Stage p0: latch the code and its step on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      code_p0 <= in_code;
      step_p0 <= step_lookup(idx_q);
    end
  end

  // Stage p1: CALC computes the magnitude delta
  always_ff @(posedge clk) begin
    if (state_q == CALC) diff_p1 <= calc_diff(step_p0, code_p0[2:0]);
  end

  // Stage p2: UPDATE commits predictor, index and output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pred_q    <= '0;
      idx_q     <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcm_valid <= 1'b0;
      if (in_valid && !in_ready) overrun <= 1'b1;
      if (clear) begin
        pred_q <= '0;
        idx_q  <= '0;
      end else if (state_q == UPDATE) begin
        pred_q    <= pred_sat;
        idx_q     <= idx_next;
        pcm_out   <= out_val;
        pcm_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_decoder.sv
module tb_adpcm_decoder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic [3:0]         in_code = 4'h0;
  logic               in_ready;
  logic               pcm_valid;
  logic signed [15:0] pcm_out;
  logic [6:0]         step_idx;
  logic               overrun;

  int checks = 0;
  int failures = 0;

  adpcm_decoder #(.PCM_W(16), .IDX_MAX(88)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .pcm_valid(pcm_valid), .pcm_out(pcm_out),
    .step_idx(step_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_code = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sends one code and waits (bounded) for its pcm_valid. lat counts edges
  // from the acceptance edge; 99 means no pulse arrived.
  task automatic decode(input logic [3:0] code, output logic signed [15:0] pcm,
                        output logic [6:0] idx, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_code = code;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!pcm_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!pcm_valid) lat = 99;
    pcm = pcm_out; idx = step_idx;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pcm_out !== 16'sd0) begin failures++; $display("FAIL reset_pcm got=%0d exp=0", pcm_out); end
    checks++; if (pcm_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pcm_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (step_idx !== 7'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", step_idx); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_single();
    logic signed [15:0] p; logic [6:0] i; int lat;
    do_reset();
    decode(4'h4, p, i, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lat); end
    checks++; if (p !== 16'sd7) begin failures++; $display("FAIL single_pcm got=%0d exp=7", p); end
    checks++; if (i !== 7'd2) begin failures++; $display("FAIL single_idx got=%0d exp=2", i); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (pcm_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", pcm_valid); end
    checks++; if (pcm_out !== 16'sd7) begin failures++; $display("FAIL single_hold got=%0d exp=7", pcm_out); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] p; logic [6:0] i; int lat;
    do_reset();
    decode(4'h7, p, i, lat);
    checks++; if (p !== 16'sd11 || i !== 7'd8) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=11/8", p, i); end
    decode(4'hF, p, i, lat);
    checks++; if (p !== -16'sd19 || i !== 7'd16) begin failures++; $display("FAIL b2b_second got=%0d/%0d exp=-19/16", p, i); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_zero_codes();
    logic signed [15:0] p; logic [6:0] i; int lat; int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      decode(4'h0, p, i, lat);
      if (p !== 16'sd0 || i !== 7'd0 || lat !== 3) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL zero_codes bad=%0d exp=0 last=%0d/%0d", bad, p, i); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] p; logic [6:0] i; logic signed [15:0] prev; int lat; int bad;
    do_reset();
    bad = 0; prev = 16'sd0;
    for (int k = 0; k < 200; k++) begin
      decode(4'h7, p, i, lat);
      if (p < prev || lat !== 3) bad++;
      prev = p;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sat_monotonic bad=%0d exp=0", bad); end
    checks++; if (p !== 16'sd32767 || i !== 7'd88) begin failures++; $display("FAIL sat_high got=%0d/%0d exp=32767/88", p, i); end
    // diff at index 88: 4095+32767+16383+8191 = 61436
    decode(4'hF, p, i, lat);
    checks++; if (p !== -16'sd28669 || i !== 7'd88) begin failures++; $display("FAIL sat_drop got=%0d/%0d exp=-28669/88", p, i); end
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      decode(4'hF, p, i, lat);
      if (p > 16'sd0 || lat !== 3) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sat_neg_wrap bad=%0d exp=0", bad); end
    checks++; if (p !== -16'sd32768 || i !== 7'd88) begin failures++; $display("FAIL sat_low got=%0d/%0d exp=-32768/88", p, i); end
  endtask

  task automatic test_overrun();
    logic signed [15:0] p; logic [6:0] i; int lat; int pulses;
    do_reset();
    pulses = 0;
    in_valid = 1'b1; in_code = 4'h4;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) in_valid = 1'b0;
      if (pcm_valid) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", pulses); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    checks++; if (pcm_out !== 16'sd7 || step_idx !== 7'd2) begin failures++; $display("FAIL overrun_data got=%0d/%0d exp=7/2", pcm_out, step_idx); end
    decode(4'h0, p, i, lat);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_rst got=%b exp=0", overrun); end
  endtask

  task automatic test_clear();
    logic signed [15:0] p; logic [6:0] i; int lat; int pulses;
    do_reset();
    decode(4'h7, p, i, lat);
    // accept 0x4, then clear while in CALC
    in_valid = 1'b1; in_code = 4'h4;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (pcm_valid) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL clear_no_valid got=%0d exp=0", pulses); end
    checks++; if (step_idx !== 7'd0) begin failures++; $display("FAIL clear_idx got=%0d exp=0", step_idx); end
    checks++; if (pcm_out !== 16'sd11) begin failures++; $display("FAIL clear_hold got=%0d exp=11", pcm_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clear_ready got=%b exp=1", in_ready); end
    decode(4'h4, p, i, lat);
    checks++; if (p !== 16'sd7 || i !== 7'd2) begin failures++; $display("FAIL clear_restart got=%0d/%0d exp=7/2", p, i); end
    // clear together with in_valid in IDLE: code dropped, not an overrun
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_code = 4'h7;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (pcm_valid || !in_ready) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL clear_idle_drop got=%0d exp=0", pulses); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clear_idle_overrun got=%b exp=0", overrun); end
    checks++; if (pcm_out !== 16'sd7 || step_idx !== 7'd0) begin failures++; $display("FAIL clear_idle_state got=%0d/%0d exp=7/0", pcm_out, step_idx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_codes();
    test_saturation();
    test_overrun();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
